// File: rtl/cnn_pkg.sv
// cnn_pkg: shared pixel/window types and window-generator FSM states
package cnn_pkg;
  localparam int CNN_WIDTH = 9;
  typedef logic signed [CNN_WIDTH-1:0] pixel_t;
  typedef pixel_t window_t [9];
  typedef enum logic [1:0] {FILL, EOL, FLUSH} state_t;
endpackage

// File: rtl/cnn_line_buffer.sv
// cnn_line_buffer: DEPTH-deep circular delay line; q is the value written DEPTH advances ago
// ports: clk, rst (async, clears pointer only), en (advance), clr (restart at slot 0), d in, q out
module cnn_line_buffer import cnn_pkg::*; #(
  parameter int WIDTH = CNN_WIDTH,
  parameter int DEPTH = 8
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic signed [WIDTH-1:0] d,
  output logic signed [WIDTH-1:0] q
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic signed [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] ptr, ptr_eff;
  assign ptr_eff = clr ? '0 : ptr;
  assign q = mem[ptr_eff];
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (en) ptr <= ptr_eff == AW'(DEPTH-1) ? '0 : ptr_eff + 1'b1;
  always_ff @(posedge clk)
    if (en) mem[ptr_eff] <= d;
endmodule

// File: rtl/cnn_window_gen.sv
// cnn_window_gen: raster pixel stream to registered 3x3 windows (W1..W9 row-major)
// ports: clk, rst (async active-high); in_valid/in_ready/in_sof/in_data pixel input;
//        out_valid/out_ready handshake, W1..W9 window, out_row/out_col centre, out_eof last of frame
// CNN_ZERO_PAD_EN: when defined, every pixel is a centre with zero outside the image
//                  (EOL emits the right-edge column, FLUSH emits the bottom row)
module cnn_window_gen import cnn_pkg::*; #(
  parameter int WIDTH = CNN_WIDTH,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sof,
  input  logic signed [WIDTH-1:0]    in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [WIDTH-1:0]    W1,
  output logic signed [WIDTH-1:0]    W2,
  output logic signed [WIDTH-1:0]    W3,
  output logic signed [WIDTH-1:0]    W4,
  output logic signed [WIDTH-1:0]    W5,
  output logic signed [WIDTH-1:0]    W6,
  output logic signed [WIDTH-1:0]    W7,
  output logic signed [WIDTH-1:0]    W8,
  output logic signed [WIDTH-1:0]    W9,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(IMG_W)-1:0]   out_col,
  output logic                       out_eof
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int FW = $clog2(IMG_W+1);
  localparam logic [RW-1:0] LAST_R = RW'(IMG_H-1);
  localparam logic [CW-1:0] LAST_C = CW'(IMG_W-1);
  localparam logic [FW-1:0] FLUSH_END = FW'(IMG_W);
`ifdef CNN_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  state_t state;
  logic [RW-1:0] rcnt, pr, er, cr;
  logic [CW-1:0] ccnt, pc, cc;
  logic [FW-1:0] fc;
  logic last_row, free, accept, emit, eof, lb_en, lb_clr, shift, mt, mb, ml, mr;
  logic signed [WIDTH-1:0] lb1q, lb2q;
  logic signed [WIDTH-1:0] s1 [3];
  logic signed [WIDTH-1:0] s2 [3];
  logic signed [WIDTH-1:0] nc [3];
  logic signed [WIDTH-1:0] win [9];
  logic signed [WIDTH-1:0] w [9];
  assign free = !out_valid || out_ready;
  assign in_ready = state == FILL && free;
  assign accept = in_valid && in_ready;
  assign pr = in_sof ? '0 : rcnt;
  assign pc = in_sof ? '0 : ccnt;
  // line buffers also advance while FLUSH walks the stored last two rows
  assign lb_en = accept || (state == FLUSH && free && fc != FLUSH_END);
  assign lb_clr = accept && in_sof;
  assign shift = accept || (state == FLUSH && free);
  cnn_line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .rst(rst), .en(lb_en), .clr(lb_clr), .d(in_data), .q(lb1q));
  cnn_line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb2 (
    .clk(clk), .rst(rst), .en(lb_en), .clr(lb_clr), .d(lb1q), .q(lb2q));
  // incoming column: rows r-2, r-1, r at the current column
  assign nc[0] = lb2q;
  assign nc[1] = lb1q;
  assign nc[2] = state == FILL ? in_data : '0;
  assign emit = state == FILL ? accept && (PAD ? pr != '0 && pc != '0 : pr >= RW'(2) && pc >= CW'(2))
                              : free && (state == EOL || fc != '0);
  assign cr = state == FILL ? pr - 1'b1 : state == EOL ? er : LAST_R;
  assign cc = state == FILL ? pc - 1'b1 : state == EOL ? LAST_C : CW'(fc - 1'b1);
  assign eof = state == FILL ? !PAD && pr == LAST_R && pc == LAST_C : state == FLUSH && fc == FLUSH_END;
  assign mt = PAD && cr == '0;
  assign mb = PAD && cr == LAST_R;
  assign ml = PAD && cc == '0;
  assign mr = PAD && cc == LAST_C;
  // window columns: s2 = left, s1 = centre, nc = right; edge masks force zero boundary
  for (genvar i = 0; i < 3; i++) begin : g_row
    for (genvar j = 0; j < 3; j++) begin : g_col
      assign win[3*i+j] = (i == 0 && mt) || (i == 2 && mb) || (j == 0 && ml) || (j == 2 && mr) ? '0
                        : j == 0 ? s2[i] : j == 1 ? s1[i] : nc[i];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FILL;
      rcnt <= '0;
      ccnt <= '0;
      fc <= '0;
      er <= '0;
      last_row <= 1'b0;
      out_valid <= 1'b0;
      out_row <= '0;
      out_col <= '0;
      out_eof <= 1'b0;
      for (int k = 0; k < 9; k++) w[k] <= '0;
      for (int k = 0; k < 3; k++) begin
        s1[k] <= '0;
        s2[k] <= '0;
      end
    end else begin
      if (accept) begin
        ccnt <= pc == LAST_C ? '0 : pc + 1'b1;
        rcnt <= pc != LAST_C ? pr : pr == LAST_R ? '0 : pr + 1'b1;
      end
      if (shift)
        for (int k = 0; k < 3; k++) begin
          s2[k] <= s1[k];
          s1[k] <= nc[k];
        end
      if (emit) begin
        out_valid <= 1'b1;
        w <= win;
        out_row <= cr;
        out_col <= cc;
        out_eof <= eof;
      end else if (out_ready) out_valid <= 1'b0;
      if (state == FILL && accept && PAD && pr != '0 && pc == LAST_C) begin
        state <= EOL;
        er <= pr - 1'b1;
        last_row <= pr == LAST_R;
      end else if (state == EOL && free) begin
        state <= last_row ? FLUSH : FILL;
        fc <= '0;
      end else if (state == FLUSH && free) begin
        fc <= fc + 1'b1;
        if (fc == FLUSH_END) state <= FILL;
      end
    end
  assign W1 = w[0];
  assign W2 = w[1];
  assign W3 = w[2];
  assign W4 = w[3];
  assign W5 = w[4];
  assign W6 = w[5];
  assign W7 = w[6];
  assign W8 = w[7];
  assign W9 = w[8];
endmodule
